ucsbece154a_controller: RTL and testbench

Multicycle RISC-V (RV32I subset) control unit. Decodes the instruction register fields and sequences the shared-ALU datapath through fetch/decode/execute/writeback, producing every datapath select and write enable, including `regwrite_o`, which drives the register file's `we3_i` port. It sits directly upstream of the register file and alongside the multicycle datapath.

---
 rtl/ucsbece154a_controller.sv | 157 +++++++++++++++
 tb/tb_ucsbece154a_controller.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ucsbece154a_controller.sv
// Multicycle RV32I-subset control unit: Moore FSM sequencing fetch/decode/execute/writeback,
// plus combinational ALU and immediate decoders driven straight from the instruction fields.
module ucsbece154a_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       zero_i,
  output logic       pcwrite_o,
  output logic       adrsrc_o,
  output logic       memwrite_o,
  output logic       irwrite_o,
  output logic [1:0] resultsrc_o,
  output logic [2:0] alucontrol_o,
  output logic [1:0] alusrca_o,
  output logic [1:0] alusrcb_o,
  output logic [1:0] immsrc_o,
  output logic       regwrite_o
);

  localparam logic [6:0] OpLw   = 7'b0000011;
  localparam logic [6:0] OpSw   = 7'b0100011;
  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpI    = 7'b0010011;
  localparam logic [6:0] OpBeq  = 7'b1100011;
  localparam logic [6:0] OpJal  = 7'b1101111;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite,
    StExecR, StExecI, StAluWb, StJal, StBeq
  } state_e;

  typedef enum logic [1:0] {AluOpAdd, AluOpSub, AluOpFunct} aluop_e;

  state_e state_q, state_d;
  aluop_e aluop;
  logic   pcupdate, branch, irwrite, memwrite, regwrite;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StFetch;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (op_i)
          OpLw, OpSw: state_d = StMemAdr;
          OpR:        state_d = StExecR;
          OpI:        state_d = StExecI;
          OpJal:      state_d = StJal;
          OpBeq:      state_d = StBeq;
          default:    state_d = StFetch;  // unsupported opcode retires as a no-op
        endcase
      end
      // IR is frozen outside FETCH, so the live opcode still names this instruction.
      StMemAdr:  state_d = (op_i == OpSw) ? StMemWrite : StMemRead;
      StMemRead: state_d = StMemWb;
      StExecR, StExecI, StJal: state_d = StAluWb;
      default:   state_d = StFetch;
    endcase
  end

  always_comb begin
    pcupdate    = 1'b0;
    branch      = 1'b0;
    irwrite     = 1'b0;
    memwrite    = 1'b0;
    regwrite    = 1'b0;
    adrsrc_o    = 1'b0;
    resultsrc_o = 2'b00;
    alusrca_o   = 2'b00;
    alusrcb_o   = 2'b00;
    aluop       = AluOpAdd;
    case (state_q)
      StFetch: begin
        irwrite     = 1'b1;
        alusrcb_o   = 2'b10;
        resultsrc_o = 2'b10;
        pcupdate    = 1'b1;
      end
      StDecode: begin
        alusrca_o = 2'b01;
        alusrcb_o = 2'b01;
      end
      StMemAdr: begin
        alusrca_o = 2'b10;
        alusrcb_o = 2'b01;
      end
      StMemRead: adrsrc_o = 1'b1;
      StMemWb: begin
        resultsrc_o = 2'b01;
        regwrite    = 1'b1;
      end
      StMemWrite: begin
        adrsrc_o = 1'b1;
        memwrite = 1'b1;
      end
      StExecR: begin
        alusrca_o = 2'b10;
        aluop     = AluOpFunct;
      end
      StExecI: begin
        alusrca_o = 2'b10;
        alusrcb_o = 2'b01;
        aluop     = AluOpFunct;
      end
      StAluWb: regwrite = 1'b1;
      StJal: begin
        alusrca_o = 2'b01;
        alusrcb_o = 2'b10;
        pcupdate  = 1'b1;
      end
      StBeq: begin
        alusrca_o = 2'b10;
        aluop     = AluOpSub;
        branch    = 1'b1;
      end
      default: ;
    endcase
    // Enables are gated by reset so nothing commits while the FSM is held in FETCH.
    pcwrite_o  = rst_n & (pcupdate | (branch & zero_i));
    irwrite_o  = rst_n & irwrite;
    memwrite_o = rst_n & memwrite;
    regwrite_o = rst_n & regwrite;
  end

  always_comb begin
    alucontrol_o = 3'b000;
    case (aluop)
      AluOpSub: alucontrol_o = 3'b001;
      AluOpFunct: begin
        case (funct3_i)
          3'b000:  alucontrol_o = (op_i[5] & funct7b5_i) ? 3'b001 : 3'b000;
          3'b010:  alucontrol_o = 3'b101;
          3'b110:  alucontrol_o = 3'b011;
          3'b111:  alucontrol_o = 3'b010;
          default: alucontrol_o = 3'b000;
        endcase
      end
      default: alucontrol_o = 3'b000;
    endcase
  end

  always_comb begin
    case (op_i)
      OpSw:    immsrc_o = 2'b01;
      OpBeq:   immsrc_o = 2'b10;
      OpJal:   immsrc_o = 2'b11;
      default: immsrc_o = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_ucsbece154a_controller.sv
// Directed bench for the multicycle controller: per-cycle model keyed by instruction class
// and cycle index, plus literal output vectors at hand-picked cycles and around reset.
module tb_ucsbece154a_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op_i = 7'b0000011;
  logic [2:0] funct3_i = 3'b000;
  logic       funct7b5_i = 1'b0;
  logic       zero_i = 1'b0;
  logic       pcwrite_o, adrsrc_o, memwrite_o, irwrite_o, regwrite_o;
  logic [1:0] resultsrc_o, alusrca_o, alusrcb_o, immsrc_o;
  logic [2:0] alucontrol_o;

  ucsbece154a_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_i        (op_i),
    .funct3_i    (funct3_i),
    .funct7b5_i  (funct7b5_i),
    .zero_i      (zero_i),
    .pcwrite_o   (pcwrite_o),
    .adrsrc_o    (adrsrc_o),
    .memwrite_o  (memwrite_o),
    .irwrite_o   (irwrite_o),
    .resultsrc_o (resultsrc_o),
    .alucontrol_o(alucontrol_o),
    .alusrca_o   (alusrca_o),
    .alusrcb_o   (alusrcb_o),
    .immsrc_o    (immsrc_o),
    .regwrite_o  (regwrite_o)
  );

  always #5 clk = ~clk;

  // {pcwrite, adrsrc, memwrite, irwrite, resultsrc, alucontrol, alusrca, alusrcb, immsrc, regwrite}
  logic [15:0] dut_vec;
  assign dut_vec = {pcwrite_o, adrsrc_o, memwrite_o, irwrite_o, resultsrc_o, alucontrol_o,
                    alusrca_o, alusrcb_o, immsrc_o, regwrite_o};

  int n_vec  = 0;
  int n_miss = 0;

  logic       m_valid = 1'b0;
  int         m_k = 0;
  string      m_name = "";

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b required %b", nm, got, exp);
    end
  endtask

  function automatic int cpi(input logic [6:0] op);
    case (op)
      7'b0000011: return 5;
      7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111: return 4;
      7'b1100011: return 3;
      default:    return 2;
    endcase
  endfunction

  function automatic logic [2:0] alu_f(input logic [6:0] op, input logic [2:0] f3,
                                       input logic f7);
    case (f3)
      3'b000:  return (op[5] && f7) ? 3'd1 : 3'd0;
      3'b010:  return 3'd5;
      3'b110:  return 3'd3;
      3'b111:  return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  // Expected outputs for cycle k of an instruction, built from the instruction class.
  function automatic logic [15:0] model(input logic [6:0] op, input logic [2:0] f3,
                                        input logic f7, input logic z, input int k);
    logic pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] ac;
    {pcw, adr, mw, irw, rw} = '0;
    rs = 0; sa = 0; sb = 0; ac = 0;
    case (op)
      7'b0100011: imm = 2'b01;
      7'b1100011: imm = 2'b10;
      7'b1101111: imm = 2'b11;
      default:    imm = 2'b00;
    endcase
    if (k == 0) begin
      irw = 1; pcw = 1; sb = 2; rs = 2;
    end else if (k == 1) begin
      sa = 1; sb = 1;
    end else begin
      case (op)
        7'b0000011: begin
          if (k == 2) begin sa = 2; sb = 1; end
          if (k == 3) adr = 1;
          if (k == 4) begin rs = 1; rw = 1; end
        end
        7'b0100011: begin
          if (k == 2) begin sa = 2; sb = 1; end
          if (k == 3) begin adr = 1; mw = 1; end
        end
        7'b0110011, 7'b0010011: begin
          if (k == 2) begin sa = 2; sb = (op == 7'b0010011) ? 2'd1 : 2'd0; ac = alu_f(op, f3, f7); end
          if (k == 3) rw = 1;
        end
        7'b1101111: begin
          if (k == 2) begin sa = 1; sb = 2; pcw = 1; end
          if (k == 3) rw = 1;
        end
        7'b1100011: begin
          sa = 2; ac = 1; pcw = z;
        end
        default: ;
      endcase
    end
    return {pcw, adr, mw, irw, rs, ac, sa, sb, imm, rw};
  endfunction

  always @(negedge clk) begin
    if (m_valid)
      check($sformatf("%s cyc%0d", m_name, m_k), dut_vec,
            model(op_i, funct3_i, funct7b5_i, zero_i, m_k));
  end

  // Drives one instruction from its FETCH cycle; peeks a literal vector at cycle peek_k.
  task automatic run_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic z, input int peek_k,
                           input logic [15:0] peek_exp);
    op_i = op; funct3_i = f3; funct7b5_i = f7; zero_i = z;
    m_name = nm;
    m_valid = 1'b1;
    for (int k = 0; k < cpi(op); k++) begin
      m_k = k;
      if (k == peek_k) begin
        #2;
        check({nm, " literal"}, dut_vec, peek_exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  localparam logic [15:0] RstVec = {4'b0000, 2'b10, 3'b000, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [15:0] FetchVec = {4'b1001, 2'b10, 3'b000, 2'b00, 2'b10, 2'b00, 1'b0};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("reset state", dut_vec, RstVec);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_instr("lw", 7'b0000011, 3'b010, 1'b0, 1'b0, 4,
              {4'b0000, 2'b01, 3'b000, 2'b00, 2'b00, 2'b00, 1'b1});
    run_instr("sw", 7'b0100011, 3'b010, 1'b0, 1'b0, 3,
              {4'b0110, 2'b00, 3'b000, 2'b00, 2'b00, 2'b01, 1'b0});
    run_instr("sub", 7'b0110011, 3'b000, 1'b1, 1'b0, 2,
              {4'b0000, 2'b00, 3'b001, 2'b10, 2'b00, 2'b00, 1'b0});
    run_instr("addi b30", 7'b0010011, 3'b000, 1'b1, 1'b0, 2,
              {4'b0000, 2'b00, 3'b000, 2'b10, 2'b01, 2'b00, 1'b0});
    run_instr("or", 7'b0110011, 3'b110, 1'b0, 1'b0, 2,
              {4'b0000, 2'b00, 3'b011, 2'b10, 2'b00, 2'b00, 1'b0});
    run_instr("and", 7'b0110011, 3'b111, 1'b0, 1'b0, 2,
              {4'b0000, 2'b00, 3'b010, 2'b10, 2'b00, 2'b00, 1'b0});
    run_instr("slt", 7'b0110011, 3'b010, 1'b0, 1'b0, 2,
              {4'b0000, 2'b00, 3'b101, 2'b10, 2'b00, 2'b00, 1'b0});
    run_instr("beq taken", 7'b1100011, 3'b000, 1'b0, 1'b1, 2,
              {4'b1000, 2'b00, 3'b001, 2'b10, 2'b00, 2'b10, 1'b0});
    run_instr("beq not taken", 7'b1100011, 3'b000, 1'b0, 1'b0, 2,
              {4'b0000, 2'b00, 3'b001, 2'b10, 2'b00, 2'b10, 1'b0});
    run_instr("jal", 7'b1101111, 3'b000, 1'b0, 1'b0, 2,
              {4'b1000, 2'b00, 3'b000, 2'b01, 2'b10, 2'b11, 1'b0});
    run_instr("jal wb", 7'b1101111, 3'b000, 1'b0, 1'b0, 3,
              {4'b0000, 2'b00, 3'b000, 2'b00, 2'b00, 2'b11, 1'b1});
    run_instr("lui unsup", 7'b0110111, 3'b000, 1'b0, 1'b0, 1,
              {4'b0000, 2'b00, 3'b000, 2'b01, 2'b01, 2'b00, 1'b0});
    run_instr("slti", 7'b0010011, 3'b010, 1'b1, 1'b0, 2,
              {4'b0000, 2'b00, 3'b101, 2'b10, 2'b01, 2'b00, 1'b0});
    run_instr("add", 7'b0110011, 3'b000, 1'b0, 1'b1, 0, FetchVec);

    // Reset asserted in the middle of MEMWB.
    op_i = 7'b0000011; funct3_i = 3'b010; funct7b5_i = 1'b0; zero_i = 1'b0;
    m_name = "lw abort";
    m_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m_k = k;
      @(posedge clk);
      #1;
    end
    m_k = 4;
    #2;
    check("memwb before reset", dut_vec, {4'b0000, 2'b01, 3'b000, 2'b00, 2'b00, 2'b00, 1'b1});
    m_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset mid-memwb", dut_vec, RstVec);
    @(posedge clk);
    #1;
    check("reset held", dut_vec, RstVec);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("fetch after release", dut_vec, FetchVec);
    run_instr("lw after reset", 7'b0000011, 3'b010, 1'b0, 1'b0, 4,
              {4'b0000, 2'b01, 3'b000, 2'b00, 2'b00, 2'b00, 1'b1});
    run_instr("beq after lw", 7'b1100011, 3'b000, 1'b0, 1'b1, 0,
              {4'b1001, 2'b10, 3'b000, 2'b00, 2'b10, 2'b10, 1'b0});
    m_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
